// File: rtl/unique_pkg.sv
// Shared definitions for the duplicate-remover pipeline: element sizing,
// FSM encoding and the compacted-frame payload.
package unique_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned N      = 9;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  typedef struct packed {
    logic [N-1:0][DATA_W-1:0] slots;
    logic [CNT_W-1:0]         len;
  } frame_t;

  // Counts above the slot capacity are silently limited to N.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] count);
    return (count > CNT_W'(N)) ? CNT_W'(N) : count;
  endfunction

endpackage

// File: rtl/unique_stream_out_if.sv
// Frame-load and byte-stream channels of the unique_stream_out stage.
interface unique_stream_out_if;
  import unique_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [N*DATA_W-1:0] in_vec;
  logic [CNT_W-1:0]    in_count;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;

  modport master (
    output in_valid, in_vec, in_count, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_vec, in_count, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/unique_stream_out.sv
// Captures one compacted frame and replays its first len slots as a
// valid/ready byte stream with a last marker and a frame_done pulse.
module unique_stream_out
  import unique_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  unique_stream_out_if.slave  bus,
  output logic                frame_done,
  output logic                busy
);

  state_e           state_q, state_d;
  frame_t           frame_q, frame_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             frame_done_d;
  logic             stream_d;
  logic [DATA_W-1:0] out_data_d;
  logic             out_last_d;

  // Next state, local frame copy and slot index.
  always_comb begin
    state_d      = state_q;
    frame_d      = frame_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          frame_d.slots = bus.in_vec;
          frame_d.len   = clamp_count(bus.in_count);
          idx_d         = '0;
          if (frame_d.len == '0) begin
            frame_done_d = 1'b1;
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (bus.out_ready) begin
          if (idx_q == frame_q.len - CNT_W'(1)) begin
            state_d      = IDLE;
            idx_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            idx_d = idx_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output values are computed from next-state so every port is a flop.
  always_comb begin
    stream_d   = (state_d == STREAM);
    out_data_d = '0;
    out_last_d = 1'b0;
    if (stream_d) begin
      out_data_d = frame_d.slots[idx_d];
      out_last_d = (idx_d == frame_d.len - CNT_W'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      idx_q         <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_last  <= 1'b0;
      frame_done    <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state_q       <= state_d;
      frame_q       <= frame_d;
      idx_q         <= idx_d;
      bus.in_ready  <= ~stream_d;
      bus.out_valid <= stream_d;
      bus.out_data  <= out_data_d;
      bus.out_last  <= out_last_d;
      frame_done    <= frame_done_d;
      busy          <= stream_d;
    end
  end

endmodule
